// File: rtl/herald_op_scheduler_if.sv
// Requester-side bundle for herald_op_scheduler: two request
// ports plus the shared response channel.
interface herald_op_scheduler_if #(
    parameter int DW = 32
) ();
    logic          req0_valid;
    logic          req0_ready;
    logic [1:0]    req0_op;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic          req1_valid;
    logic          req1_ready;
    logic [1:0]    req1_op;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/herald_op_scheduler.sv
// Round-robin scheduler sharing one CORDIC and one MAC engine
// between two requesters, with a watchdog on result collection.
module herald_op_scheduler #(
    parameter int            DW          = 32,
    parameter logic [DW-1:0] CORDIC_K    = 32'h00004DBA,
    parameter logic [1:0]    CORDIC_MODE = 2'b00,
    parameter int            TIMEOUT     = 64
) (
    input  logic          clk,
    input  logic          rst,
    herald_op_scheduler_if.slave bus,
    output logic          busy,
    output logic          cordic_start_en,
    input  logic          cordic_start_rdy,
    output logic [DW-1:0] cordic_x,
    output logic [DW-1:0] cordic_y,
    output logic [DW-1:0] cordic_z,
    output logic [1:0]    cordic_mode,
    output logic          cordic_get_en,
    input  logic          cordic_get_rdy,
    input  logic [DW-1:0] cordic_result,
    output logic [1:0]    mac_op,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    output logic          mac_start_en,
    input  logic          mac_start_rdy,
    output logic          mac_get_en,
    input  logic          mac_get_rdy,
    input  logic [DW-1:0] mac_result
);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE, ISSUE, WAIT, RESP
    } state_t;

    state_t        state, state_nx;
    logic          prio;
    logic [WDW-1:0] wd;
    logic [1:0]    op_q;
    logic [DW-1:0] a_q, b_q, data_q;
    logic          id_q, err_q;

    logic grant0, grant1, accept;
    logic tgt_cordic, start_rdy, get_rdy, wd_max;

    // prio only breaks ties; a lone requester always wins
    assign grant0 = bus.req0_valid & (~bus.req1_valid | ~prio);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | prio);
    assign accept = grant0 | grant1;

    assign tgt_cordic = (op_q == 2'b11);
    assign start_rdy  = tgt_cordic ? cordic_start_rdy : mac_start_rdy;
    assign get_rdy    = tgt_cordic ? cordic_get_rdy : mac_get_rdy;
    assign wd_max     = (wd == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = ISSUE;
            ISSUE: if (start_rdy)
                       state_nx = (op_q == 2'b10) ? RESP : WAIT;
            WAIT:  if (get_rdy | wd_max) state_nx = RESP;
            RESP:  if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // enables are gated by rst so a reset cycle never fires an engine
    always_comb begin
        bus.req0_ready  = (state == IDLE) & grant0 & ~rst;
        bus.req1_ready  = (state == IDLE) & grant1 & ~rst;
        cordic_start_en = (state == ISSUE) & tgt_cordic
                        & cordic_start_rdy & ~rst;
        mac_start_en    = (state == ISSUE) & ~tgt_cordic
                        & mac_start_rdy & ~rst;
        cordic_get_en   = (state == WAIT) & tgt_cordic
                        & cordic_get_rdy & ~rst;
        mac_get_en      = (state == WAIT) & ~tgt_cordic
                        & mac_get_rdy & ~rst;
        bus.rsp_valid   = (state == RESP);
        busy            = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio   <= 1'b0;
            wd     <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    id_q <= grant1;
                    op_q <= grant1 ? bus.req1_op : bus.req0_op;
                    a_q  <= grant1 ? bus.req1_a : bus.req0_a;
                    b_q  <= grant1 ? bus.req1_b : bus.req0_b;
                end
                ISSUE: if (start_rdy) begin
                    wd <= '0;
                    if (op_q == 2'b10) begin
                        data_q <= '0;
                        err_q  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (get_rdy) begin
                        data_q <= tgt_cordic ? cordic_result
                                             : mac_result;
                        err_q  <= 1'b0;
                    end else if (wd_max) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                RESP: if (bus.rsp_ready) prio <= ~id_q;
                default: ;
            endcase
        end
    end

    assign bus.rsp_id   = id_q;
    assign bus.rsp_data = data_q;
    assign bus.rsp_err  = err_q;
    assign cordic_x     = CORDIC_K;
    assign cordic_y     = '0;
    assign cordic_z     = a_q;
    assign cordic_mode  = CORDIC_MODE;
    assign mac_op       = op_q;
    assign mac_a        = a_q;
    assign mac_b        = b_q;
endmodule

// File: tb/tb_herald_op_scheduler.sv
// Directed bench for herald_op_scheduler: multiply, contention,
// CORDIC stall, clear, watchdog, backpressure and reset.
module tb_herald_op_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    herald_op_scheduler_if #(.DW(32)) bus ();

    logic        busy;
    logic        cordic_start_en, cordic_start_rdy;
    logic [31:0] cordic_x, cordic_y, cordic_z;
    logic [1:0]  cordic_mode;
    logic        cordic_get_en, cordic_get_rdy;
    logic [31:0] cordic_result;
    logic [1:0]  mac_op;
    logic [31:0] mac_a, mac_b;
    logic        mac_start_en, mac_start_rdy;
    logic        mac_get_en, mac_get_rdy;
    logic [31:0] mac_result;

    herald_op_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.slave),
        .busy             (busy),
        .cordic_start_en  (cordic_start_en),
        .cordic_start_rdy (cordic_start_rdy),
        .cordic_x         (cordic_x),
        .cordic_y         (cordic_y),
        .cordic_z         (cordic_z),
        .cordic_mode      (cordic_mode),
        .cordic_get_en    (cordic_get_en),
        .cordic_get_rdy   (cordic_get_rdy),
        .cordic_result    (cordic_result),
        .mac_op           (mac_op),
        .mac_a            (mac_a),
        .mac_b            (mac_b),
        .mac_start_en     (mac_start_en),
        .mac_start_rdy    (mac_start_rdy),
        .mac_get_en       (mac_get_en),
        .mac_get_rdy      (mac_get_rdy),
        .mac_result       (mac_result)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int mac_st_cnt  = 0;
    int mac_get_cnt = 0;

    always @(posedge clk) begin
        if (mac_start_en) mac_st_cnt  <= mac_st_cnt + 1;
        if (mac_get_en)   mac_get_cnt <= mac_get_cnt + 1;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      tag, got, exp);
    endtask

    task automatic issue(input bit port, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (port) begin
            bus.req1_valid = 1'b1; bus.req1_op = op;
            bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op;
            bus.req0_a = a; bus.req0_b = b;
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    int n;
    int both_cnt;
    bit ok;
    int g_id[$];
    int g_cyc[$];
    int s0, g0;

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
        bus.req0_a = 32'd7;    bus.req0_b = 32'd6;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00;
        bus.req1_a = '0;       bus.req1_b = '0;
        bus.rsp_ready = 1'b0;
        cordic_start_rdy = 1'b0; cordic_get_rdy = 1'b0;
        cordic_result = '0;
        mac_start_rdy = 1'b1; mac_get_rdy = 1'b1;
        mac_result = 32'd42;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_mac_en", mac_start_en, 0);
        check("rst_mac_a", mac_a, 0);
        check("rst_cordic_z", cordic_z, 0);
        check("rst_rsp_data", bus.rsp_data, 0);

        // single multiply on port 0
        rst = 1'b0;
        #1 check("mul_ready0", bus.req0_ready, 1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        check("mul_start_en", mac_start_en, 1);
        check("mul_op", mac_op, 2'b00);
        check("mul_ab", {mac_a, mac_b}, {32'd7, 32'd6});
        check("mul_cordic_quiet", cordic_start_en, 0);
        @(negedge clk); #1;
        check("mul_get_en", mac_get_en, 1);
        check("mul_start_pulse", mac_start_en, 0);
        @(negedge clk); #1;
        check("mul_rsp",
              {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data},
              {1'b1, 1'b0, 1'b0, 32'd42});
        handshake();
        #1 check("mul_idle", busy, 0);

        // backpressure on port 1
        mac_result = 32'h55AA;
        issue(1, 2'b00, 32'd5, 32'd5);
        wait_rsp(10, n);
        check("bp_latency", n, 2);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 ||
                bus.rsp_data !== 32'h55AA || bus.rsp_err !== 1'b0)
                ok = 1'b0;
        end
        check("bp_stable", ok, 1);
        handshake();

        // reset in the middle of WAIT
        mac_get_rdy = 1'b0;
        issue(0, 2'b00, 32'd1, 32'd1);
        @(negedge clk); #1;
        check("wait_busy", busy, 1);
        rst = 1'b1;
        mac_get_rdy = 1'b1;
        #1 check("rst_get_drop", mac_get_en, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rsp", bus.rsp_valid, 0);
        check("rst_mid_mac_a", mac_a, 0);

        // contention straight out of reset
        mac_result = 32'd1;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b00;
        bus.rsp_ready = 1'b1;
        both_cnt = 0;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both_cnt++;
            if (bus.req0_ready) begin g_id.push_back(0); g_cyc.push_back(c); end
            if (bus.req1_ready) begin g_id.push_back(1); g_cyc.push_back(c); end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        bus.rsp_ready = 1'b0;
        check("cont_both_ready", both_cnt, 0);
        check("cont_count", g_id.size(), 5);
        if (g_id.size() >= 4) begin
            check("cont_order",
                  {g_id[0][3:0], g_id[1][3:0], g_id[2][3:0], g_id[3][3:0]},
                  16'h0101);
            check("cont_spacing", g_cyc[1] - g_cyc[0], 4);
        end

        // CORDIC rotate on port 1 with delayed start_rdy
        cordic_get_rdy = 1'b1;
        cordic_result = 32'h1234;
        issue(1, 2'b11, 32'h40, 32'h99);
        ok = 1'b1;
        repeat (3) begin
            #1 if (cordic_start_en !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        check("cor_stall", ok, 1);
        cordic_start_rdy = 1'b1;
        #1;
        check("cor_start_en", cordic_start_en, 1);
        check("cor_xyz", {cordic_x, cordic_y, cordic_z},
              {32'h4DBA, 32'h0, 32'h40});
        check("cor_mode", cordic_mode, 2'b00);
        check("cor_mac_quiet", mac_start_en, 0);
        @(negedge clk);
        cordic_start_rdy = 1'b0;
        #1 check("cor_get_en", cordic_get_en, 1);
        @(negedge clk); #1;
        check("cor_rsp",
              {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data},
              {1'b1, 1'b1, 1'b0, 32'h1234});
        handshake();

        // clear accumulator
        s0 = mac_st_cnt;
        g0 = mac_get_cnt;
        issue(0, 2'b10, 32'h11, 32'h22);
        #1;
        check("clr_start_en", mac_start_en, 1);
        check("clr_op", mac_op, 2'b10);
        @(negedge clk); #1;
        check("clr_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data},
              {1'b1, 1'b0, 32'h0});
        handshake();
        check("clr_pulses", {mac_st_cnt - s0, mac_get_cnt - g0},
              {32'd1, 32'd0});

        // watchdog expiry, then a normal op
        mac_get_rdy = 1'b0;
        mac_result = 32'd99;
        issue(0, 2'b00, 32'd3, 32'd5);
        #1 check("wd_start_en", mac_start_en, 1);
        wait_rsp(200, n);
        check("wd_latency", n, 65);
        check("wd_rsp", {bus.rsp_id, bus.rsp_err, bus.rsp_data},
              {1'b0, 1'b1, 32'h0});
        handshake();
        mac_get_rdy = 1'b1;
        mac_result = 32'd18;
        issue(1, 2'b01, 32'd2, 32'd9);
        #1 check("wd_next_op", mac_op, 2'b01);
        wait_rsp(10, n);
        check("wd_next_lat", n, 2);
        check("wd_next_rsp", {bus.rsp_id, bus.rsp_err, bus.rsp_data},
              {1'b1, 1'b0, 32'd18});
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
